// File: rtl/sched_pkg.sv
// Shared types and constants for the time-shared max-priority scheduler.
// The state encoding and the priority/requester limits live here.
package sched_pkg;

  localparam int PRIO_W   = 4;
  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cmp_ge4.sv
// Combinational 4-bit unsigned A >= B comparator. The scheduler owns exactly one
// of these and reuses it for every requester, one per cycle.
module cmp_ge4
  import sched_pkg::*;
(
  input  logic [PRIO_W-1:0] a_i,
  input  logic [PRIO_W-1:0] b_i,
  output logic              d_o
);

  logic gt;
  logic eq;

  // MSB-first cascade: the first differing bit decides, equality falls through.
  always_comb begin
    gt = 1'b0;
    eq = 1'b1;
    for (int i = PRIO_W - 1; i >= 0; i--) begin
      gt = gt | (eq & a_i[i] & ~b_i[i]);
      eq = eq & ~(a_i[i] ^ b_i[i]);
    end
    d_o = gt | eq;
  end

endmodule

// File: rtl/sched_max4.sv
// Picks the highest-priority active requester by scanning one requester per cycle
// through a single shared comparator; lowest index wins ties.
module sched_max4
  import sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NREQ-1:0]          req,
  input  logic [PRIO_W*NREQ-1:0]   prio,
  output logic                     busy,
  output logic                     done,
  output logic [NREQ-1:0]          grant,
  output logic                     grant_valid,
  output logic [PRIO_W-1:0]        win_prio
);

  localparam int IDX_W = $clog2(NREQ);

  state_e                   state_q;
  logic [NREQ-1:0]          reqSnap_q;
  logic [PRIO_W*NREQ-1:0]   prioSnap_q;
  logic [IDX_W-1:0]         idx_q;
  logic [IDX_W-1:0]         bestIdx_q;
  logic [PRIO_W-1:0]        bestPrio_q;
  logic                     haveBest_q;
  logic                     busy_q;
  logic                     done_q;
  logic [NREQ-1:0]          grant_q;
  logic                     grantValid_q;
  logic [PRIO_W-1:0]        winPrio_q;

  logic [PRIO_W-1:0]        curPrio;
  logic                     curReq;
  logic                     bestGeCur;
  logic                     candWins;
  logic                     lastIdx;
  logic [NREQ-1:0]          grant_d;

  always_comb begin
    curPrio = '0;
    curReq  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (idx_q == IDX_W'(i)) begin
        curPrio = prioSnap_q[i*PRIO_W +: PRIO_W];
        curReq  = reqSnap_q[i];
      end
    end
  end

  cmp_ge4 u_cmp (
    .a_i (bestPrio_q),
    .b_i (curPrio),
    .d_o (bestGeCur)
  );

  // A candidate only displaces the current best when strictly greater.
  assign candWins = curReq & (~haveBest_q | ~bestGeCur);
  assign lastIdx  = (idx_q == IDX_W'(NREQ - 1));

  always_comb begin
    grant_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bestIdx_q == IDX_W'(i)) begin
        grant_d[i] = 1'b1;
      end
    end
  end

  // done and the result are registered as the FSM leaves DONE, so they appear
  // together in the cycle after the DONE edge and the result then holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      reqSnap_q    <= '0;
      prioSnap_q   <= '0;
      idx_q        <= '0;
      bestIdx_q    <= '0;
      bestPrio_q   <= '0;
      haveBest_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      grant_q      <= '0;
      grantValid_q <= 1'b0;
      winPrio_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            reqSnap_q    <= req;
            prioSnap_q   <= prio;
            idx_q        <= '0;
            bestIdx_q    <= '0;
            bestPrio_q   <= '0;
            haveBest_q   <= 1'b0;
            grant_q      <= '0;
            grantValid_q <= 1'b0;
            winPrio_q    <= '0;
            busy_q       <= 1'b1;
            state_q      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (candWins) begin
            bestIdx_q  <= idx_q;
            bestPrio_q <= curPrio;
            haveBest_q <= 1'b1;
          end
          if (lastIdx) begin
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (haveBest_q) begin
            grant_q      <= grant_d;
            grantValid_q <= 1'b1;
            winPrio_q    <= bestPrio_q;
          end else begin
            grant_q      <= '0;
            grantValid_q <= 1'b0;
            winPrio_q    <= '0;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign grant       = grant_q;
  assign grant_valid = grantValid_q;
  assign win_prio    = winPrio_q;

endmodule

// File: tb/tb_sched_max4.sv
// Directed bench for sched_max4 (NREQ=4): a vector table of single rounds plus
// hand-written sequences for input changes mid-round, held start and mid-round reset.
module tb_sched_max4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  req;
  logic [15:0] prio;
  logic        busy;
  logic        done;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [3:0]  win_prio;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [3:0]  req;
    logic [15:0] prio;
    logic [3:0]  expGrant;
    logic        expValid;
    logic [3:0]  expWinPrio;
  } vec_t;

  vec_t vecs[8];

  sched_max4 #(.NREQ(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .req         (req),
    .prio        (prio),
    .busy        (busy),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .win_prio    (win_prio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Returns the number of rising edges until done is seen, or -1 on timeout.
  task automatic waitDone(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int lat;
    @(negedge clk);
    req   = v.req;
    prio  = v.prio;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({v.name, " busy_in_scan"}, 32'(busy), 32'd1);
    checkOutput({v.name, " valid_cleared"}, 32'(grant_valid), 32'd0);
    waitDone(lat);
    checkOutput({v.name, " latency"}, 32'(lat), 32'd5);
    checkOutput({v.name, " grant"}, 32'(grant), 32'(v.expGrant));
    checkOutput({v.name, " grant_valid"}, 32'(grant_valid), 32'(v.expValid));
    checkOutput({v.name, " win_prio"}, 32'(win_prio), 32'(v.expWinPrio));
    checkOutput({v.name, " busy_after"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({v.name, " done_one_cycle"}, 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput({v.name, " grant_hold"}, 32'(grant), 32'(v.expGrant));
    checkOutput({v.name, " win_prio_hold"}, 32'(win_prio), 32'(v.expWinPrio));
  endtask

  initial begin
    int  lat;
    bit  sawDone;

    vecs[0] = '{"basic",     4'b1111, 16'h2951, 4'b0100, 1'b1, 4'h9};
    vecs[1] = '{"tie_all",   4'b1111, 16'h7777, 4'b0001, 1'b1, 4'h7};
    vecs[2] = '{"masked",    4'b1010, 16'hFFFF, 4'b0010, 1'b1, 4'hF};
    vecs[3] = '{"no_req",    4'b0000, 16'h1234, 4'b0000, 1'b0, 4'h0};
    vecs[4] = '{"zero_vs_f", 4'b0011, 16'h00F0, 4'b0010, 1'b1, 4'hF};
    vecs[5] = '{"only_top0", 4'b1000, 16'h0ABC, 4'b1000, 1'b1, 4'h0};
    vecs[6] = '{"tie_mid",   4'b0110, 16'h3553, 4'b0010, 1'b1, 4'h5};
    vecs[7] = '{"skip_one",  4'b1101, 16'hE1C4, 4'b1000, 1'b1, 4'hE};

    rst_n = 1'b0;
    start = 1'b0;
    req   = '0;
    prio  = '0;
    #12;
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst grant", 32'(grant), 32'd0);
    checkOutput("rst grant_valid", 32'(grant_valid), 32'd0);
    checkOutput("rst win_prio", 32'(win_prio), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end

    // Inputs and start change during the scan; the snapshot must still win.
    @(negedge clk);
    req   = 4'b1111;
    prio  = 16'h2951;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    req   = 4'b0001;
    prio  = 16'hFFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(lat);
    checkOutput("snap latency", 32'(lat), 32'd3);
    checkOutput("snap grant", 32'(grant), 32'h4);
    checkOutput("snap win_prio", 32'(win_prio), 32'h9);
    @(posedge clk);
    #1;
    checkOutput("snap no_restart", 32'(busy), 32'd0);

    // Start held high: second round is accepted one IDLE cycle after DONE.
    @(negedge clk);
    req   = 4'b0101;
    prio  = 16'h0302;
    start = 1'b1;
    @(posedge clk);
    #1;
    waitDone(lat);
    checkOutput("held latency1", 32'(lat), 32'd5);
    checkOutput("held idle_gap", 32'(busy), 32'd0);
    checkOutput("held grant1", 32'(grant), 32'h4);
    checkOutput("held win_prio1", 32'(win_prio), 32'h3);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("held restart_busy", 32'(busy), 32'd1);
    checkOutput("held restart_done", 32'(done), 32'd0);
    checkOutput("held restart_clear", 32'(grant), 32'd0);
    waitDone(lat);
    checkOutput("held latency2", 32'(lat), 32'd5);
    checkOutput("held grant2", 32'(grant), 32'h4);

    // Reset during SCAN at idx=2 aborts with no done pulse.
    @(negedge clk);
    req   = 4'b1101;
    prio  = 16'hE1C4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort grant", 32'(grant), 32'd0);
    checkOutput("abort grant_valid", 32'(grant_valid), 32'd0);
    checkOutput("abort win_prio", 32'(win_prio), 32'd0);
    sawDone = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("abort no_done", 32'(sawDone), 32'd0);
    @(negedge clk);
    start = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("post_rst accept", 32'(busy), 32'd1);
    waitDone(lat);
    checkOutput("post_rst latency", 32'(lat), 32'd5);
    checkOutput("post_rst grant", 32'(grant), 32'h8);
    checkOutput("post_rst win_prio", 32'(win_prio), 32'hE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sched_max4.md
SCHED_MAX4 -- requirements
Module: sched_max4

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, legal range 2..8: number of requesters sharing the comparator.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request one arbitration round.
REQ-005 The block SHALL have port req, input, NREQ bits: request flag per requester.
REQ-006 The block SHALL have port prio, input, 4*NREQ bits: 4-bit unsigned priority per requester; requester i occupies bits [4i+3:4i].
REQ-007 The block SHALL have port busy, output, 1 bit: a round is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle end-of-round pulse.
REQ-009 The block SHALL have port grant, output, NREQ bits: one-hot winner, or all zero.
REQ-010 The block SHALL have port grant_valid, output, 1 bit: grant holds a winner.
REQ-011 The block SHALL have port win_prio, output, 4 bits: priority of the winner.

Function
REQ-012 The block SHALL time-share exactly one 4-bit A>=B comparator across all requesters, evaluating one requester per cycle.
REQ-013 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-014 In IDLE, start=1 SHALL snapshot req and prio, clear grant/grant_valid/win_prio, set idx=0 and have_best=0, and go to SCAN; later input changes do not affect the round.
REQ-015 In SCAN, each cycle SHALL evaluate requester idx: if its snapshot req is 1 and (have_best=0 or NOT(best_prio >= prio[idx])), then best_idx=idx, best_prio=prio[idx] and have_best=1.
REQ-016 Comparator operands SHALL be A=best_prio and B=prio[idx]; a strict-greater candidate wins, so on equal priority the lowest index wins.
REQ-017 After idx=NREQ-1 is evaluated, SCAN SHALL go to DONE; idx never wraps within a round.
REQ-018 In DONE, for one cycle: done=1; grant=one-hot(best_idx) with grant_valid=1 and win_prio=best_prio if have_best=1, else grant=0, grant_valid=0, win_prio=0; then go to IDLE.
REQ-019 grant, grant_valid and win_prio SHALL hold their DONE values until the next accepted start.
REQ-020 Latency: with start sampled high at rising edge k, done SHALL be high in the cycle after edge k+NREQ+1, for exactly one cycle.
REQ-021 busy SHALL be 1 in SCAN and DONE and 0 in IDLE.
REQ-022 start SHALL be ignored while busy=1; start held high through DONE SHALL be accepted at the first IDLE edge, giving back-to-back rounds with one IDLE cycle between them.
REQ-023 An all-zero req snapshot SHALL still complete the full NREQ-cycle scan and pulse done with grant_valid=0.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE and busy=0, done=0, grant=0, grant_valid=0, win_prio=0, idx=0, have_best=0, with no clock edge required.
REQ-025 Reset asserted mid-round SHALL abort the round with no done pulse; after reset release, the block SHALL accept start on the first clock edge.

Structure
REQ-026 The state encoding type, the priority width constant (4) and NREQ limits SHALL live in the shared package sched_pkg.
REQ-027 The comparator SHALL be a single instance of the combinational sub-module cmp_ge4 (4-bit A, 4-bit B, D=A>=B); the controller SHALL not contain a second magnitude compare.

Verification
REQ-028 Scenario: NREQ=4, req=1111, prio={3:0x2, 2:0x9, 1:0x5, 0:0x1}, start pulse -> done after 5 cycles, grant=0100, grant_valid=1, win_prio=0x9.
REQ-029 Scenario: tie, req=1111, all prio=0x7 -> grant=0001, win_prio=0x7.
REQ-030 Scenario: req=1010, prio={3:0xF, 1:0xF, 2:0xF, 0:0xF} -> grant=0010 (masked requesters never win).
REQ-031 Scenario: req=0000 -> done pulses once, grant=0000, grant_valid=0, win_prio=0; boundary prio 0x0 vs 0xF with req=0011, prio1=0xF, prio0=0x0 -> grant=0010.
REQ-032 Scenario: start re-asserted and req/prio changed during SCAN -> ignored, result matches the snapshot; start held high -> second round begins one IDLE cycle after DONE.
REQ-033 Scenario: rst_n pulled low during SCAN (idx=2) -> outputs zero immediately, no done pulse; new round after release -> correct result.
